// File: rtl/uart_fifo_sched.sv
// uart_fifo_sched: write arbiter and read sequencer around a shared 128x8 UART FIFO.
// Two byte producers share the active-low FIFO write strobe (round-robin or fixed
// priority); a small read FSM pops one byte at a time, waits out the FIFO read
// latency and holds the byte on a valid/ready handshake towards the transmitter.
`timescale 1ns/1ps
module uart_fifo_sched #(
  parameter int PRIO_MODE = 0,
  parameter int RD_LAT    = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req0,
  input  logic [7:0]       data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [7:0]       data1,
  output logic             ack1,
  output logic             fifo_wrb,
  output logic [7:0]       fifo_din,
  input  logic             fifo_full,
  output logic             fifo_rdb,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] tx_count
);

  // Latency counter start value: R_WAIT lasts RD_LAT cycles, the last one
  // being the cycle in which fifo_dout holds the popped byte.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_POP  = 2'd1,
    R_WAIT = 2'd2,
    R_HOLD = 2'd3
  } rd_state_t;

  // Write side state
  logic             wrb_r;
  logic [7:0]       din_r;
  logic             ack0_r;
  logic             ack1_r;
  logic             last_grant_r;
  logic             win_s;
  logic             grant_s;

  // Read side state
  rd_state_t        state_r;
  rd_state_t        state_nx;
  logic             rdb_r;
  logic [1:0]       lat_cnt_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;
  logic [CNT_W-1:0] tx_count_r;

  // Winner selection among the requesting ports.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      if (PRIO_MODE != 0) begin
        win_s = 1'b0;
      end else begin
        // Round-robin: the port that did not win last time.
        win_s = ~last_grant_r;
      end
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // A grant slot exists only when no write happened this cycle, so FULL
  // always reflects the previous write before the next one is issued.
  always_comb begin
    grant_s = 1'b0;
    if (wrb_r && !fifo_full && (req0 || req1)) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Registered write strobe, write data, acknowledges and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wrb_r        <= 1'b1;
      din_r        <= 8'h00;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (grant_s) begin
      wrb_r        <= 1'b0;
      din_r        <= win_s ? data1 : data0;
      ack0_r       <= ~win_s;
      ack1_r       <= win_s;
      last_grant_r <= win_s;
    end else begin
      wrb_r        <= 1'b1;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
    end
  end

  // Read FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= R_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Read FSM next-state logic; fifo_empty is only looked at in R_IDLE.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      R_IDLE: begin
        if (!fifo_empty && !tx_valid_r) begin
          state_nx = R_POP;
        end else begin
          state_nx = R_IDLE;
        end
      end
      R_POP: begin
        state_nx = R_WAIT;
      end
      R_WAIT: begin
        if (lat_cnt_r == 2'd0) begin
          state_nx = R_HOLD;
        end else begin
          state_nx = R_WAIT;
        end
      end
      R_HOLD: begin
        if (tx_ready) begin
          state_nx = R_IDLE;
        end else begin
          state_nx = R_HOLD;
        end
      end
      default: begin
        state_nx = R_IDLE;
      end
    endcase
  end

  // Read datapath: registered read strobe, latency counter, tx byte and count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rdb_r      <= 1'b1;
      lat_cnt_r  <= 2'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_count_r <= {CNT_W{1'b0}};
    end else begin
      // Strobe is low for exactly the one cycle spent in R_POP.
      rdb_r <= (state_nx == R_POP) ? 1'b0 : 1'b1;
      case (state_r)
        R_POP: begin
          lat_cnt_r <= LAT_INIT;
        end
        R_WAIT: begin
          if (lat_cnt_r == 2'd0) begin
            tx_data_r  <= fifo_dout;
            tx_valid_r <= 1'b1;
          end else begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
          end
        end
        R_HOLD: begin
          if (tx_ready) begin
            tx_valid_r <= 1'b0;
            tx_count_r <= tx_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            tx_valid_r <= 1'b1;
          end
        end
        default: begin
          lat_cnt_r <= lat_cnt_r;
        end
      endcase
    end
  end

  assign ack0     = ack0_r;
  assign ack1     = ack1_r;
  assign fifo_wrb = wrb_r;
  assign fifo_din = din_r;
  assign fifo_rdb = rdb_r;
  assign tx_valid = tx_valid_r;
  assign tx_data  = tx_data_r;
  assign tx_count = tx_count_r;

endmodule

// File: tb/tb_uart_fifo_sched.sv
// tb_uart_fifo_sched: directed bench with a FIFO model, request producers, a
// timestamp/scoreboard reference model compared every cycle, and literal checks.
`timescale 1ns/1ps
module tb_uart_fifo_sched;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 16;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [7:0]       data0 = 8'h00, data1 = 8'h00;
  logic             ack0, ack1, fifo_wrb, fifo_rdb, tx_valid;
  logic [7:0]       fifo_din, tx_data;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout = 8'h00;
  logic             tx_ready = 1'b0;
  logic [CNT_W-1:0] tx_count;
  // Second instance (fixed priority) outputs
  logic             p_ack0, p_ack1, p_wrb, p_rdb, p_txv;
  logic [7:0]       p_din, p_txd;
  logic [CNT_W-1:0] p_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // FIFO model state
  logic [7:0] fq[$];
  int         fcount = 0;
  logic       force_full = 1'b0;
  assign fifo_full  = force_full | (fcount >= 128);
  assign fifo_empty = (fcount == 0);

  // Producer queues
  logic [7:0] q0[$], q1[$];

  // Observation logs
  int         wr_cyc[$], wr_port[$], rd_cyc[$], rise_cyc[$], p0_cyc[$];
  logic [7:0] wr_dat[$], out_b[$];
  int         p1_cnt = 0;
  logic       prev_v = 1'b0;

  // Reference model state
  logic             e_wrb, e_ack0, e_ack1, e_rdb, e_val, last, busy;
  logic [7:0]       e_din, e_txd, pend;
  logic [CNT_W-1:0] e_cnt;
  int               pop_at;
  logic [7:0]       sb[$];

  uart_fifo_sched #(.PRIO_MODE(0), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .fifo_wrb(fifo_wrb), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_rdb(fifo_rdb), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_count(tx_count)
  );

  uart_fifo_sched #(.PRIO_MODE(1), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut_prio (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .data0(data0), .ack0(p_ack0),
    .req1(req1), .data1(data1), .ack1(p_ack1),
    .fifo_wrb(p_wrb), .fifo_din(p_din), .fifo_full(fifo_full),
    .fifo_rdb(p_rdb), .fifo_dout(8'h00), .fifo_empty(1'b1),
    .tx_valid(p_txv), .tx_data(p_txd), .tx_ready(1'b0), .tx_count(p_cnt)
  );

  always #5 CLK = ~CLK;

  // Cycle index: value c throughout cycle c.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #3;
    end
  endtask

  // FIFO model: push/pop on the edge, popped byte on fifo_dout RD_LAT cycles
  // after the strobe cycle, garbage in between.
  initial begin : fifo_model
    logic       sw, sr;
    logic [7:0] sd, pb;
    int         pc;
    pc = 0;
    pb = 8'h00;
    forever begin
      @(negedge CLK);
      sw = fifo_wrb;
      sr = fifo_rdb;
      sd = fifo_din;
      @(posedge CLK);
      #1;
      if (!RESET) begin
        fq.delete();
        pc = 0;
        fifo_dout = 8'h00;
      end else begin
        if (pc > 0) begin
          pc--;
          if (pc == 0) fifo_dout = pb;
        end
        if (!sr && fq.size() > 0) begin
          pb = fq.pop_front();
          pc = RD_LAT - 1;
          fifo_dout = (pc == 0) ? pb : 8'hEE;
        end
        if (!sw && fq.size() < 128) fq.push_back(sd);
      end
      fcount = fq.size();
    end
  end

  // Producers: hold req until ack, then drop or present the next byte at n+2.
  initial begin : producers
    logic a0, a1;
    forever begin
      @(negedge CLK);
      a0 = ack0;
      a1 = ack1;
      @(posedge CLK);
      #2;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      req0  = (q0.size() > 0);
      data0 = req0 ? q0[0] : 8'h00;
      req1  = (q1.size() > 0);
      data1 = req1 ? q1[0] : 8'h00;
    end
  end

  task automatic model_reset();
    e_wrb = 1'b1; e_ack0 = 1'b0; e_ack1 = 1'b0; e_din = 8'h00; last = 1'b1;
    e_rdb = 1'b1; e_val = 1'b0; e_txd = 8'h00; e_cnt = '0; busy = 1'b0;
    pop_at = 0; pend = 8'h00;
    sb.delete();
  endtask

  // Predict outputs of cycle cyc+1 from the inputs of cycle cyc.
  task automatic model_step();
    logic win, was_idle;
    if (e_wrb && !fifo_full && (req0 || req1)) begin
      win = (req0 && req1) ? ~last : req1;
      e_wrb = 1'b0; e_ack0 = ~win; e_ack1 = win;
      e_din = win ? data1 : data0;
      last = win;
      sb.push_back(e_din);
    end else begin
      e_wrb = 1'b1; e_ack0 = 1'b0; e_ack1 = 1'b0;
    end
    was_idle = !busy;
    if (e_val && tx_ready) begin
      e_val = 1'b0;
      e_cnt = e_cnt + 1'b1;
      busy = 1'b0;
    end
    if (was_idle && !fifo_empty) begin
      busy = 1'b1;
      pop_at = cyc + 1;
      if (sb.size() > 0) pend = sb.pop_front();
      else pend = 8'hxx;
    end
    e_rdb = !(busy && (cyc + 1 == pop_at));
    // Capture edge closes cycle pop+RD_LAT, so tx_valid is seen one cycle later.
    if (busy && !e_val && (cyc + 1 == pop_at + RD_LAT + 1)) begin
      e_val = 1'b1;
      e_txd = pend;
    end
  endtask

  // Per-cycle comparison against the model, plus event logging.
  initial begin : compare
    model_reset();
    forever begin
      @(negedge CLK);
      if (!RESET) model_reset();
      checks++;
      if ({ack0, ack1, fifo_wrb, fifo_rdb, tx_valid, fifo_din, tx_data, tx_count} !==
          {e_ack0, e_ack1, e_wrb, e_rdb, e_val, e_din, e_txd, e_cnt}) begin
        errors++;
        $display("FAIL model cyc=%0d got ack=%b%b wrb=%b rdb=%b v=%b din=%h txd=%h cnt=%0d exp ack=%b%b wrb=%b rdb=%b v=%b din=%h txd=%h cnt=%0d",
                 cyc, ack0, ack1, fifo_wrb, fifo_rdb, tx_valid, fifo_din, tx_data, tx_count,
                 e_ack0, e_ack1, e_wrb, e_rdb, e_val, e_din, e_txd, e_cnt);
      end
      if (!fifo_wrb) begin
        wr_cyc.push_back(cyc);
        wr_dat.push_back(fifo_din);
        wr_port.push_back(ack1 ? 1 : 0);
      end
      if (!fifo_rdb) rd_cyc.push_back(cyc);
      if (tx_valid && !prev_v) rise_cyc.push_back(cyc);
      prev_v = tx_valid;
      if (tx_valid && tx_ready) out_b.push_back(tx_data);
      if (p_ack0) p0_cyc.push_back(cyc);
      if (p_ack1) p1_cnt++;
      if (RESET) model_step();
    end
  end

  task automatic do_reset();
    RESET = 1'b0;
    q0.delete();
    q1.delete();
    tick(2);
    RESET = 1'b1;
    wr_cyc.delete(); wr_dat.delete(); wr_port.delete(); rd_cyc.delete();
    rise_cyc.delete(); out_b.delete(); p0_cyc.delete(); p1_cnt = 0;
    tick(1);
  endtask

  initial begin : stimulus
    int n, d;
    logic [7:0] exp_b[4];
    tick(2);
    // Reset values, both instances
    chk("rst_dut", {ack0, ack1, fifo_wrb, fifo_rdb, tx_valid, fifo_din, tx_data, tx_count},
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000});
    chk("rst_prio", {p_ack0, p_ack1, p_wrb, p_rdb, p_txv, p_din, p_txd, p_cnt},
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000});
    RESET = 1'b1;
    tick(1);

    // Single byte through write and read paths
    q0.push_back(8'h41);
    tick(12);
    chk("t1_wr_n", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) begin
      chk("t1_wr_data", wr_dat[0], 8'h41);
      chk("t1_wr_port", wr_port[0], 0);
    end
    chk("t1_rd_n", rd_cyc.size(), 1);
    if (rd_cyc.size() == 1 && wr_cyc.size() == 1) chk("t1_rd_gap", rd_cyc[0] - wr_cyc[0], 2);
    if (rise_cyc.size() == 1 && rd_cyc.size() == 1) chk("t1_valid_lat", rise_cyc[0] - rd_cyc[0], RD_LAT + 1);
    chk("t1_tx", {tx_valid, tx_data}, {1'b1, 8'h41});
    tx_ready = 1'b1;
    tick(3);
    chk("t1_count", tx_count, 1);

    // Round-robin with both ports held
    do_reset();
    q0.push_back(8'hA0); q0.push_back(8'hA1);
    q1.push_back(8'hB0); q1.push_back(8'hB1);
    tick(16);
    exp_b[0] = 8'hA0; exp_b[1] = 8'hB0; exp_b[2] = 8'hA1; exp_b[3] = 8'hB1;
    chk("t2_wr_n", wr_cyc.size(), 4);
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      chk("t2_port", wr_port[i], i % 2);
      chk("t2_data", wr_dat[i], exp_b[i]);
      if (i > 0) chk("t2_gap", wr_cyc[i] - wr_cyc[i-1], 2);
    end
    tick(40);
    chk("t2_count", tx_count, 4);
    for (int i = 0; i < 4 && i < out_b.size(); i++) chk("t2_out", out_b[i], exp_b[i]);

    // Fixed priority instance: only port 0 acknowledged while both held
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(8'h60 + 8'(i));
      q1.push_back(8'h70 + 8'(i));
    end
    tick(14);
    chk("t3_ack1_never", p1_cnt, 0);
    chk("t3_ack0_ge6", (p0_cyc.size() >= 6) ? 1 : 0, 1);
    for (int i = 1; i < 6 && i < p0_cyc.size(); i++) chk("t3_gap", p0_cyc[i] - p0_cyc[i-1], 2);
    tick(100);
    chk("t3_count", tx_count, 12);

    // FULL blocks grants; byte survives
    do_reset();
    force_full = 1'b1;
    q1.push_back(8'h5A);
    tick(6);
    chk("t4_blocked", wr_cyc.size(), 0);
    force_full = 1'b0;
    d = cyc;
    tick(4);
    chk("t4_wr_n", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) begin
      chk("t4_wr_cyc", wr_cyc[0], d + 1);
      chk("t4_wr_port", wr_port[0], 1);
      chk("t4_wr_data", wr_dat[0], 8'h5A);
    end

    // Back-pressure: one pop only, byte held stable
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) q0.push_back(8'h10 + 8'(i));
    tick(28);
    chk("t5_one_pop", rd_cyc.size(), 1);
    chk("t5_hold", {tx_valid, tx_data}, {1'b1, 8'h10});
    tx_ready = 1'b1;
    tick(30);
    chk("t5_count", tx_count, 4);
    chk("t5_out_n", out_b.size(), 4);
    for (int i = 0; i < 4 && i < out_b.size(); i++) chk("t5_out", out_b[i], 8'h10 + 8'(i));

    // Reset while in R_WAIT
    do_reset();
    q0.push_back(8'h21); q0.push_back(8'h77);
    n = 0;
    while (rd_cyc.size() < 2 && n < 40) begin
      tick(1);
      n++;
    end
    chk("t6_pop2_seen", rd_cyc.size(), 2);
    chk("t6_pre_count", tx_count, 1);
    RESET = 1'b0;
    #1;
    chk("t6_async", {tx_valid, fifo_rdb, tx_count}, {1'b0, 1'b1, 16'h0000});
    // Reset while holding a byte
    do_reset();
    tx_ready = 1'b0;
    q0.push_back(8'h66);
    n = 0;
    while (!tx_valid && n < 30) begin
      tick(1);
      n++;
    end
    chk("t6_hold_seen", tx_valid, 1'b1);
    RESET = 1'b0;
    #1;
    chk("t6_drop_valid", {tx_valid, tx_data}, {1'b0, 8'h00});
    // Reset during a write strobe
    do_reset();
    q1.push_back(8'h33);
    n = 0;
    while (fifo_wrb && n < 10) begin
      tick(1);
      n++;
    end
    chk("t6_wr_seen", fifo_wrb, 1'b0);
    RESET = 1'b0;
    #1;
    chk("t6_wr_abort", {fifo_wrb, ack1}, {1'b1, 1'b0});
    // Normal operation resumes
    do_reset();
    tx_ready = 1'b1;
    q0.push_back(8'h5C);
    tick(20);
    chk("t6_resume_count", tx_count, 1);
    chk("t6_resume_n", out_b.size(), 1);
    if (out_b.size() == 1) chk("t6_resume_byte", out_b[0], 8'h5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
